// File: rtl/spi_reg_pkg.sv
// ============================================================================
// spi_reg_pkg - shared types and constants for the SPI register bank. Rev 1.0
// ============================================================================
`default_nettype none

package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        WAIT = 2'd3
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync.sv
// ============================================================================
// spi_sync - 2-FF synchronizer with optional registered-history edge outputs.
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_sync #(
    parameter bit EDGES = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;

    // Reset to 0 so a line held low across reset never produces a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

    generate
        if (EDGES) begin : g_edges
            logic prev_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= sync_q;
                end
            end

            assign rise_o = sync_q & ~prev_q;
            assign fall_o = ~sync_q & prev_q;
        end else begin : g_no_edges
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/spi_reg_bank.sv
// ============================================================================
// spi_reg_bank - SPI mode-0 slave with NUM_REGS x DATA_W register bank.
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk_i,
    input  logic                         cs_n_i,
    input  logic                         sdi_i,
    output logic                         sdo_o,
    output logic                         sdo_oe_o,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat_o,
    output logic                         wr_stb_o,
    output logic [ADDR_W-1:0]            wr_addr_o,
    output logic                         frame_err_o
);

    localparam int FLEN  = frame_len(ADDR_W, DATA_W);
    localparam int CNT_W = $clog2(FLEN + 1);
    localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(FLEN - 1);
    localparam logic [CNT_W-1:0]  FLEN_C    = CNT_W'(FLEN);
    localparam logic [ADDR_W:0]   NREGS_C   = (ADDR_W+1)'(NUM_REGS);

    logic sclk_unused, cs_unused, sdi_rise_unused, sdi_fall_unused;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, sdi_s;

    spi_sync #(.EDGES(1'b1)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk_i),
        .q_o(sclk_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync #(.EDGES(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(cs_n_i),
        .q_o(cs_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync #(.EDGES(1'b0)) u_sync_sdi (
        .clk(clk), .rst(rst), .d_i(sdi_i),
        .q_o(sdi_s), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   cmd_q, cmd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                sdo_q, sdo_d;
    logic                sdo_oe_q, sdo_oe_d;
    logic                wr_stb_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                frame_err_q, frame_err_d;
    logic                commit;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [ADDR_W-1:0]   addr_cmd;
    logic [DATA_W-1:0]   rd_word;
    logic                addr_ok;

    // Address as it stands on the address-complete sample, including the live bit.
    assign addr_cmd = {cmd_q[ADDR_W-2:0], sdi_s};
    assign addr_ok  = ({1'b0, addr_q} < NREGS_C);

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_cmd == ADDR_W'(k)) begin
                rd_word = regs_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cs_fall) state_d = CMD;
            CMD: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise && cnt_q == CMD_LAST) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise && cnt_q == DATA_LAST) begin
                    state_d = WAIT;
                end
            end
            WAIT: if (cs_rise || sclk_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        sdo_d       = sdo_q;
        sdo_oe_d    = sdo_oe_q;
        frame_err_d = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE: cnt_d = '0;
            CMD: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    cmd_d = addr_cmd;
                    if (cnt_q == CMD_LAST) begin
                        rw_d   = cmd_q[ADDR_W-1];
                        addr_d = addr_cmd;
                        tx_d   = rd_word;
                    end
                end
            end
            DATA: begin
                if (cs_rise) begin
                    frame_err_d = 1'b1;
                end else begin
                    if (sclk_rise) begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        data_d = {data_q[DATA_W-2:0], sdi_s};
                    end
                    if (sclk_fall && rw_q == RW_READ) begin
                        sdo_d    = tx_q[DATA_W-1];
                        tx_d     = tx_q << 1;
                        sdo_oe_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cs_rise) begin
                    commit = (rw_q == RW_WRITE) && (cnt_q == FLEN_C) && addr_ok;
                end else if (sclk_rise) begin
                    frame_err_d = 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
        // Read data phase ends on the trailing falling edge or when the frame ends.
        if (state_d == IDLE || (state_q == WAIT && sclk_fall)) begin
            sdo_d    = 1'b0;
            sdo_oe_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            tx_q        <= '0;
            rw_q        <= RW_READ;
            addr_q      <= '0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            wr_stb_q    <= commit;
            frame_err_q <= frame_err_d;
            if (commit) begin
                wr_addr_q <= addr_q;
            end
            for (int k = 0; k < NUM_REGS; k++) begin
                if (commit && addr_q == ADDR_W'(k)) begin
                    regs_q[k] <= data_q;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
            assign regs_flat_o[k*DATA_W +: DATA_W] = regs_q[k];
        end
    endgenerate

    assign sdo_o       = sdo_q;
    assign sdo_oe_o    = sdo_oe_q;
    assign wr_stb_o    = wr_stb_q;
    assign wr_addr_o   = wr_addr_q;
    assign frame_err_o = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
// ============================================================================
// tb_spi_reg_bank - directed bench for default and 12x16 register bank builds.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_reg_bank;

    localparam int HALF = 6;
    localparam int GAP  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         sclk0 = 1'b0, cs_n0 = 1'b1, sdi0 = 1'b0;
    logic         sdo0, sdo_oe0, wr_stb0, frame_err0;
    logic [39:0]  regs_flat0;
    logic [6:0]   wr_addr0;

    logic         sclk1 = 1'b0, cs_n1 = 1'b1, sdi1 = 1'b0;
    logic         sdo1, sdo_oe1, wr_stb1, frame_err1;
    logic [191:0] regs_flat1;
    logic [3:0]   wr_addr1;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_cnt0 = 0, err_cnt0 = 0, stb_cnt1 = 0, err_cnt1 = 0;
    int width_bad = 0, sdo_bad = 0;
    logic stb_prev0 = 1'b0, err_prev0 = 1'b0, stb_prev1 = 1'b0, err_prev1 = 1'b0;

    always #5 clk = ~clk;

    spi_reg_bank u_dut0 (
        .clk(clk), .rst(rst), .sclk_i(sclk0), .cs_n_i(cs_n0), .sdi_i(sdi0),
        .sdo_o(sdo0), .sdo_oe_o(sdo_oe0), .regs_flat_o(regs_flat0),
        .wr_stb_o(wr_stb0), .wr_addr_o(wr_addr0), .frame_err_o(frame_err0)
    );

    spi_reg_bank #(.NUM_REGS(12), .DATA_W(16), .ADDR_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .sclk_i(sclk1), .cs_n_i(cs_n1), .sdi_i(sdi1),
        .sdo_o(sdo1), .sdo_oe_o(sdo_oe1), .regs_flat_o(regs_flat1),
        .wr_stb_o(wr_stb1), .wr_addr_o(wr_addr1), .frame_err_o(frame_err1)
    );

    // Pulse counters plus width and sdo-quiet monitors.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_stb0)    stb_cnt0 <= stb_cnt0 + 1;
            if (frame_err0) err_cnt0 <= err_cnt0 + 1;
            if (wr_stb1)    stb_cnt1 <= stb_cnt1 + 1;
            if (frame_err1) err_cnt1 <= err_cnt1 + 1;
            if ((wr_stb0 && stb_prev0) || (frame_err0 && err_prev0) ||
                (wr_stb1 && stb_prev1) || (frame_err1 && err_prev1))
                width_bad <= width_bad + 1;
            if ((!sdo_oe0 && sdo0) || (!sdo_oe1 && sdo1))
                sdo_bad <= sdo_bad + 1;
        end
        stb_prev0 <= wr_stb0;
        err_prev0 <= frame_err0;
        stb_prev1 <= wr_stb1;
        err_prev1 <= frame_err1;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pin_cs(input int sel, input logic v);
        if (sel == 0) cs_n0 = v; else cs_n1 = v;
    endtask

    task automatic pin_sclk(input int sel, input logic v);
        if (sel == 0) sclk0 = v; else sclk1 = v;
    endtask

    task automatic pin_sdi(input int sel, input logic v);
        if (sel == 0) sdi0 = v; else sdi1 = v;
    endtask

    // Drives nbits MSB first; samples sdo where the master would (just before each rise).
    task automatic spi_frame(input int sel, input int nbits, input logic [31:0] bits,
                             input bit raise_cs, output logic [31:0] rx, output int oe_n);
        logic oe_v, sdo_v;
        rx   = '0;
        oe_n = 0;
        pin_cs(sel, 1'b0);
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            pin_sdi(sel, bits[nbits-1-i]);
            wait_clk(HALF);
            oe_v  = (sel == 0) ? sdo_oe0 : sdo_oe1;
            sdo_v = (sel == 0) ? sdo0 : sdo1;
            if (oe_v) begin
                rx = {rx[30:0], sdo_v};
                oe_n++;
            end
            pin_sclk(sel, 1'b1);
            wait_clk(HALF);
            pin_sclk(sel, 1'b0);
        end
        wait_clk(HALF);
        if (raise_cs) begin
            pin_cs(sel, 1'b1);
            wait_clk(GAP);
        end
    endtask

    typedef struct {
        int          nbits;
        logic [31:0] bits;
        int          exp_stb;
        int          exp_err;
        logic [39:0] exp_regs;
        logic [6:0]  exp_waddr;
        int          exp_oe;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] rx;
        int          oe_n, s0, e0;

        vecs[0]  = '{16, 32'h82A5,  1, 0, 40'h00_00_A5_00_00, 7'd2, 0, 32'h00};
        vecs[1]  = '{16, 32'h0200,  0, 0, 40'h00_00_A5_00_00, 7'd2, 8, 32'hA5};
        vecs[2]  = '{16, 32'h90FF,  0, 0, 40'h00_00_A5_00_00, 7'd2, 0, 32'h00};
        vecs[3]  = '{16, 32'h1000,  0, 0, 40'h00_00_A5_00_00, 7'd2, 8, 32'h00};
        vecs[4]  = '{12, 32'h813,   0, 1, 40'h00_00_A5_00_00, 7'd2, 0, 32'h00};
        vecs[5]  = '{17, 32'h10022, 0, 1, 40'h00_00_A5_00_00, 7'd2, 0, 32'h00};
        vecs[6]  = '{16, 32'h845A,  1, 0, 40'h5A_00_A5_00_00, 7'd4, 0, 32'h00};
        vecs[7]  = '{16, 32'h8577,  0, 0, 40'h5A_00_A5_00_00, 7'd4, 0, 32'h00};
        vecs[8]  = '{16, 32'h0400,  0, 0, 40'h5A_00_A5_00_00, 7'd4, 8, 32'h5A};
        vecs[9]  = '{16, 32'h80FF,  1, 0, 40'h5A_00_A5_00_FF, 7'd0, 0, 32'h00};
        vecs[10] = '{16, 32'h0000,  0, 0, 40'h5A_00_A5_00_FF, 7'd0, 8, 32'hFF};

        // cs_n already low while reset is released.
        cs_n0 = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(4);
        check("reset regs0", regs_flat0, '0);
        check("reset regs1", regs_flat1, '0);
        check("reset wr_stb", wr_stb0, 0);
        check("reset wr_addr", wr_addr0, 0);
        check("reset frame_err", frame_err0, 0);
        check("reset sdo", sdo0, 0);
        check("reset sdo_oe", sdo_oe0, 0);

        s0 = stb_cnt0; e0 = err_cnt0;
        spi_frame(0, 16, 32'h82A5, 1'b1, rx, oe_n);
        check("cs low at reset stb", stb_cnt0 - s0, 0);
        check("cs low at reset err", err_cnt0 - e0, 0);
        check("cs low at reset regs", regs_flat0, '0);

        for (int i = 0; i < 11; i++) begin
            s0 = stb_cnt0; e0 = err_cnt0;
            spi_frame(0, vecs[i].nbits, vecs[i].bits, 1'b1, rx, oe_n);
            check($sformatf("v%0d wr_stb", i), stb_cnt0 - s0, vecs[i].exp_stb);
            check($sformatf("v%0d frame_err", i), err_cnt0 - e0, vecs[i].exp_err);
            check($sformatf("v%0d regs", i), regs_flat0, vecs[i].exp_regs);
            check($sformatf("v%0d wr_addr", i), wr_addr0, vecs[i].exp_waddr);
            check($sformatf("v%0d oe count", i), oe_n, vecs[i].exp_oe);
            check($sformatf("v%0d rx", i), rx, vecs[i].exp_rx);
            check($sformatf("v%0d oe idle", i), sdo_oe0, 0);
        end

        // Commit latency: wr_stb and regs move on the 3rd clk after cs_n rises.
        spi_frame(0, 16, 32'h8311, 1'b0, rx, oe_n);
        cs_n0 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_clk(1);
            check($sformatf("latency stb clk%0d", k), wr_stb0, (k == 3) ? 1 : 0);
            check($sformatf("latency regs clk%0d", k), regs_flat0,
                  (k >= 3) ? 40'h5A_11_A5_00_FF : 40'h5A_00_A5_00_FF);
        end
        wait_clk(GAP);

        // Reset mid-frame, then the rest of the same frame must be ignored.
        s0 = stb_cnt0; e0 = err_cnt0;
        spi_frame(0, 10, 32'h813C >> 6, 1'b0, rx, oe_n);
        wait_clk(1);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        spi_frame(0, 6, 32'h813C & 32'h3F, 1'b1, rx, oe_n);
        check("abort regs", regs_flat0, '0);
        check("abort stb", stb_cnt0 - s0, 0);
        check("abort err", err_cnt0 - e0, 0);

        s0 = stb_cnt0;
        spi_frame(0, 16, 32'h813C, 1'b1, rx, oe_n);
        check("rewrite regs", regs_flat0, 40'h00_00_00_3C_00);
        check("rewrite stb", stb_cnt0 - s0, 1);
        check("rewrite wr_addr", wr_addr0, 1);

        // Wide build: reg11 = 0xBEEF, then read it back.
        spi_frame(1, 21, 32'h1BBEEF, 1'b1, rx, oe_n);
        check("wide regs", regs_flat1, {16'hBEEF, 176'd0});
        check("wide stb", stb_cnt1, 1);
        check("wide wr_addr", wr_addr1, 4'd11);
        spi_frame(1, 21, 32'h0B0000, 1'b1, rx, oe_n);
        check("wide rx", rx, 32'hBEEF);
        check("wide oe count", oe_n, 16);
        check("wide err", err_cnt1, 0);
        check("wide stb after read", stb_cnt1, 1);

        check("pulse width", width_bad, 0);
        check("sdo quiet", sdo_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI-slave register bank, the next generation of the design's SPI configuration front end. It receives SPI mode-0 frames from off-chip pins and holds NUM_REGS registers of DATA_W bits that drive downstream peripherals such as the PWM block. New over the previous generation: configurable register count and width, register read-back on sdo with an output enable, a per-write strobe, and detection of malformed frames.

## Interface

- NUM_REGS, 5: number of registers; valid addresses 0..NUM_REGS-1.
- DATA_W, 8: register width in bits.
- ADDR_W, 7: address field width; must satisfy 2**ADDR_W >= NUM_REGS.

- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high; the top level drives it as ~rst_n.
- sclk  in  1  SPI clock, asynchronous to clk.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- sdi  in  1  SPI data from master, asynchronous.
- sdo  out  1  SPI read data to master.
- sdo_oe  out  1  high while sdo is driven (read frame, data phase, cs_n low).
- regs_flat  out  NUM_REGS*DATA_W  register contents; reg k occupies bits [k*DATA_W +: DATA_W].
- wr_stb  out  1  one-cycle pulse when a write commits.
- wr_addr  out  ADDR_W  address of the last committed write; valid while wr_stb is high, held otherwise.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

## Operation

- Frame format, MSB first: 1 rw bit (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits. FRAME_LEN = 1 + ADDR_W + DATA_W (16 at the defaults).
- sclk, cs_n and sdi each pass through a 2-FF synchronizer. Edge detection runs on the synchronized sclk and cs_n.
- Bits are sampled on the synchronized rising edge of sclk. sdo changes on the synchronized falling edge (mode 0).
- FSM states:
  - IDLE: waits for cs_n falling; clears the bit counter.
  - CMD: shifts in rw and address. After bit 1+ADDR_W, moves to DATA.
  - DATA: shifts in data bits, or shifts out read data.
  - WAIT: reached at bit FRAME_LEN; waits for cs_n rising.
- cs_n rising in any state other than IDLE returns the FSM to IDLE.
- Write commit:
  - Condition: cs_n rises in WAIT, rw=1, bit count exactly FRAME_LEN, address < NUM_REGS.
  - Action: the register updates, wr_stb pulses and wr_addr loads, all in the same clk cycle.
- Write to address >= NUM_REGS: no register change, no wr_stb, no frame_err.
- Read frame:
  - On the address-complete sample, the shift-out register loads reg[addr], or 0 if addr >= NUM_REGS.
  - sdo presents the MSB from the next sclk falling edge and shifts on each later falling edge.
  - No register changes. wr_stb stays low.
- Discard: cs_n rises with bit count != FRAME_LEN, or more than FRAME_LEN rising edges arrive. Result: frame_err pulses, no commit, FSM returns to IDLE.
- sdo is 0 whenever sdo_oe is low. The top level maps sdo_oe onto its uio_oe bit.
- Reset: all registers 0, regs_flat 0, wr_stb 0, wr_addr 0, frame_err 0, sdo 0, sdo_oe 0, FSM IDLE, counters 0.
- Reset asserted mid-frame aborts the frame with no commit and no frame_err. The next frame starts only at a fresh cs_n falling edge.
- cs_n already low when reset deasserts: the frame is ignored until cs_n goes high and then low again.

## Timing

- Input-to-internal latency: 2 clk (synchronizer) plus 1 clk (edge register).
- sclk high and low phases must each be ≥ 4 clk cycles. cs_n setup to the first sclk rising edge and hold after the last falling edge must each be ≥ 4 clk.
- Write: regs_flat and wr_stb change 3 clk after the pin-level cs_n rising edge.
- Read: sdo changes 3 clk after the pin-level sclk falling edge.
- wr_stb and frame_err are exactly 1 clk wide. Back-to-back frames with cs_n high ≥ 4 clk must both commit.
- All outputs are registered; there are no combinational paths from pins to outputs.

## Structure

- Package spi_reg_pkg holds:
  - the state enum (IDLE, CMD, DATA, WAIT);
  - the RW_WRITE / RW_READ constants;
  - a FRAME_LEN function of ADDR_W and DATA_W.
- Sub-module spi_sync: parametrised 2-FF synchronizer with rising/falling edge outputs. It is instantiated once each for sclk and cs_n; sdi uses it without edge outputs.
- The register array is an unpacked array of DATA_W vectors, flattened onto regs_flat.

## Test plan

- Write rw=1, addr=0x02, data=0xA5 at defaults → reg2=0xA5, wr_stb one pulse with wr_addr=2, other registers 0.
- After that write, read rw=0, addr=0x02 → sdo shifts out 1010_0101 MSB first, sdo_oe high for exactly 8 falling edges, no wr_stb.
- Write addr=0x10, data=0xFF → regs_flat unchanged, no wr_stb, no frame_err. A read of addr 0x10 returns 0x00.
- Write frame cut to 12 bits, then a 17-bit frame → frame_err pulses once per frame, registers unchanged.
- rst asserted 1 clk after bit 10 of a write of 0x3C to reg1 → reg1=0, no wr_stb. A subsequent full write of 0x3C commits normally.
- NUM_REGS=12, DATA_W=16, ADDR_W=4: write reg11=0xBEEF, then read it back → regs_flat[191:176]=0xBEEF, sdo returns 0xBEEF.
